pong_engine: RTL
================

# pong_engine

Parametrised two-player successor to the single-paddle `pong_game` block. It runs one ball and two paddles (left and right), and each paddle is either AI-tracked or driven by up/down buttons. The block also keeps per-player scores and sequences serve, play and game-over through a state machine. It sits between the VGA timing generator, which supplies `frame_start`, and the pixel renderer, which consumes the positions, scores and state.

## Interface
- `H_RES`, 640, active pixels per line
- `V_RES`, 480, active lines
- `BALL_SIZE`, 8, ball edge length in px
- `PADDLE_W`, 8, paddle width in px
- `PADDLE_H`, 64, paddle height in px
- `BALL_SPEED`, 2, ball step per frame on each axis
- `PADDLE_SPEED`, 3, maximum paddle step per frame
- `SERVE_FRAMES`, 60, frames the ball waits at centre before play
- `WIN_SCORE`, 9, score that ends the game
- `SCORE_W`, 4, score width
- `clk`  in  1  system/pixel clock
- `reset_n`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  frame tick from VGA timing; acts on its rising edge
- `mode`  in  2  per-paddle mode: bit0 = left, bit1 = right; 0 = AI, 1 = manual
- `btn_up`  in  2  manual up request: bit0 = left, bit1 = right
- `btn_down`  in  2  manual down request: bit0 = left, bit1 = right
- `restart`  in  1  leave GAME_OVER
- `ball_x`, `ball_y`  out  10 each  ball top-left position
- `paddle_l_y`, `paddle_r_y`  out  10 each  paddle top y; paddle x is fixed at 0 (left) and H_RES-PADDLE_W (right)
- `score_l`, `score_r`  out  SCORE_W each  player scores
- `state`  out  2  0 = SERVE, 1 = PLAY, 2 = GAME_OVER
- `game_over`  out  1  high while in GAME_OVER

## Operation
- Reset values:
  - ball = (H_RES/2, V_RES/2); direction dx = +, dy = +
  - paddles = (V_RES-PADDLE_H)/2
  - scores = 0; state = SERVE; serve counter = SERVE_FRAMES; game_over = 0
- Tick = `frame_start` high this cycle and low the previous cycle (registered edge detect). A multi-cycle pulse counts as one tick. Nothing changes between ticks.
- SERVE:
  - Each tick decrements the serve counter. Ball is held at centre; paddles still update.
  - On the tick where the counter reaches 0, go to PLAY. The ball does not move on that tick.
- PLAY, per tick, with all values computed from pre-tick registers:
  - Paddle, AI mode: target = ball_y + BALL_SIZE/2 - PADDLE_H/2. Step toward the target by min(PADDLE_SPEED, |target-y|).
  - Paddle, manual mode: up only gives -PADDLE_SPEED; down only gives +PADDLE_SPEED; both or neither gives 0.
  - Paddle result is always clamped to [0, V_RES-PADDLE_H].
  - Vertical: next_y = ball_y ± BALL_SPEED.
    - If next_y >= V_RES-BALL_SIZE: set y = V_RES-BALL_SIZE and dy = −.
    - If next_y <= 0: set y = 0 and dy = +.
  - Horizontal: next_x = ball_x ± BALL_SPEED.
    - Right limit is H_RES-PADDLE_W-BALL_SIZE; left limit is PADDLE_W.
    - When next_x crosses a limit, test overlap against the updated paddle: next_y+BALL_SIZE > pad_y and next_y < pad_y+PADDLE_H.
    - Hit: x = limit, dx flips, scores unchanged.
    - Miss: the opposite player's score increments. Ball returns to centre with dx toward the conceding player and dy unchanged. Serve counter reloads; state goes to SERVE.
    - If the incremented score equals WIN_SCORE, go to GAME_OVER instead of SERVE.
- GAME_OVER:
  - Ball is held at centre, paddles freeze, game_over = 1.
  - A tick with `restart` = 1 clears both scores, reloads the serve counter and goes to SERVE.
- Arithmetic uses 11-bit signed intermediates so no position wraps; outputs are always inside the screen.
- Scores never exceed WIN_SCORE.

## Timing
- All outputs are registered. They change on the clock edge that samples the tick cycle and are visible one cycle after the `frame_start` rising edge. There is no further latency.
- `reset_n` low clears all registers immediately, independent of `clk`, including mid-PLAY and mid-serve.
- Release of `reset_n` is synchronised internally. The first tick is honoured no earlier than 2 cycles after release.
- `btn_*`, `mode` and `restart` are sampled only in tick cycles; the block has no other handshake.

## Test plan
- **Reset.** Hold `reset_n` low for 5 clk, then release. Required: ball (320,240), both paddles 208, scores 0, state 0, game_over 0.
- **Serve then move.** Set SERVE_FRAMES = 4 and send 4 ticks. Required: state = 1 and ball still at (320,240). After 10 more ticks: ball (340,260).
- **Wall bounce.** Manual mode, no buttons. Required: ball_y = 472 at play tick 116, then 470 at tick 117, with x = 552 then 554.
- **Miss.** Same setup, continue to play tick 152 (next_x = 624, next_y = 400, no overlap with the right paddle at 208..271). Required: score_l = 1, ball (320,240), state = 0, dx = +.
- **Game over.** WIN_SCORE = 2, same stimulus, continue to the second miss. Required: score_l = 2, state = 2, game_over = 1, ball frozen. A tick with restart = 1 gives scores 0 and state 0.
- **AI rally and robustness.**
  - Both paddles AI for 2000 ticks: both scores stay 0.
  - A 3-cycle `frame_start` pulse advances the ball exactly one step.
  - Asserting `reset_n` mid-PLAY returns all outputs to reset values before the next clk edge.

Source files
------------

// File: rtl/pong_engine.sv
// pong_engine: two-paddle pong engine; ball, paddles, scores and serve/play/game-over
// sequencing advance once per rising edge of frame_start.
module pong_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic [1:0]         btn_up,
  input  logic [1:0]         btn_down,
  input  logic               restart,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [9:0]         paddle_l_y,
  output logic [9:0]         paddle_r_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state,
  output logic               game_over
);
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  localparam logic signed [10:0] CX   = 11'(H_RES / 2);
  localparam logic signed [10:0] CY   = 11'(V_RES / 2);
  localparam logic signed [10:0] P0   = 11'((V_RES - PADDLE_H) / 2);
  localparam logic signed [10:0] PMAX = 11'(V_RES - PADDLE_H);
  localparam logic signed [10:0] YMAX = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] RLIM = 11'(H_RES - PADDLE_W - BALL_SIZE);
  localparam logic signed [10:0] LLIM = 11'(PADDLE_W);
  localparam logic signed [10:0] BSZ  = 11'(BALL_SIZE);
  localparam logic signed [10:0] PH   = 11'(PADDLE_H);
  localparam logic signed [10:0] BS   = 11'(BALL_SPEED);
  localparam logic signed [10:0] PS   = 11'(PADDLE_SPEED);
  localparam logic signed [10:0] AOFF = 11'(BALL_SIZE / 2 - PADDLE_H / 2);
  localparam logic [15:0]        SF   = 16'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
  state_t r_state, w_state;
  logic [1:0] r_sync;
  logic r_fs, r_go, r_dxn, r_dyn, w_dxn, w_dyn, w_tick, w_dyn_v, w_hit_l, w_hit_r;
  logic [15:0] r_cnt, w_cnt;
  logic signed [10:0] r_bx, r_by, r_pl, r_pr, w_bx, w_by, w_pl, w_pr;
  logic signed [10:0] w_nx, w_ny, w_y, w_pl_n, w_pr_n;
  logic [SCORE_W-1:0] r_sl, r_sr, w_sl, w_sr;
  function automatic logic signed [10:0] f_pad(input logic signed [10:0] py, by,
                                               input logic man, up, dn);
    logic signed [10:0] d, s, n;
    d = by + AOFF - py;
    s = man ? ((up && !dn) ? -PS : (dn && !up) ? PS : 11'sd0)
            : (d > PS ? PS : d < -PS ? -PS : d);
    n = py + s;
    return n < 11'sd0 ? 11'sd0 : n > PMAX ? PMAX : n;
  endfunction
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sync  <= '0;
      r_fs    <= 1'b0;
      r_state <= SERVE;
      r_go    <= 1'b0;
      r_cnt   <= SF;
      r_bx    <= CX;
      r_by    <= CY;
      r_pl    <= P0;
      r_pr    <= P0;
      r_dxn   <= 1'b0;
      r_dyn   <= 1'b0;
      r_sl    <= '0;
      r_sr    <= '0;
    end else begin
      r_sync  <= {r_sync[0], 1'b1};
      r_fs    <= frame_start;
      r_state <= w_state;
      r_go    <= w_state == OVER;
      r_cnt   <= w_cnt;
      r_bx    <= w_bx;
      r_by    <= w_by;
      r_pl    <= w_pl;
      r_pr    <= w_pr;
      r_dxn   <= w_dxn;
      r_dyn   <= w_dyn;
      r_sl    <= w_sl;
      r_sr    <= w_sr;
    end
  // ticks are ignored until the synchronised reset release has propagated
  always_comb begin
    w_tick  = frame_start && !r_fs && r_sync[1];
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bx    = r_bx;
    w_by    = r_by;
    w_pl    = r_pl;
    w_pr    = r_pr;
    w_dxn   = r_dxn;
    w_dyn   = r_dyn;
    w_sl    = r_sl;
    w_sr    = r_sr;
    w_pl_n  = f_pad(r_pl, r_by, mode[0], btn_up[0], btn_down[0]);
    w_pr_n  = f_pad(r_pr, r_by, mode[1], btn_up[1], btn_down[1]);
    w_ny    = r_dyn ? r_by - BS : r_by + BS;
    w_nx    = r_dxn ? r_bx - BS : r_bx + BS;
    w_y     = w_ny >= YMAX ? YMAX : w_ny <= 11'sd0 ? 11'sd0 : w_ny;
    w_dyn_v = w_ny >= YMAX ? 1'b1 : w_ny <= 11'sd0 ? 1'b0 : r_dyn;
    w_hit_l = (w_ny + BSZ > w_pl_n) && (w_ny < w_pl_n + PH);
    w_hit_r = (w_ny + BSZ > w_pr_n) && (w_ny < w_pr_n + PH);
    if (w_tick) begin
      if (r_state == SERVE) begin
        w_pl    = w_pl_n;
        w_pr    = w_pr_n;
        w_cnt   = r_cnt == 16'd0 ? 16'd0 : r_cnt - 16'd1;
        w_state = r_cnt <= 16'd1 ? PLAY : SERVE;
      end else if (r_state == PLAY) begin
        w_pl  = w_pl_n;
        w_pr  = w_pr_n;
        w_by  = w_y;
        w_dyn = w_dyn_v;
        w_bx  = w_nx;
        if (!r_dxn && w_nx >= RLIM) begin
          w_bx  = w_hit_r ? RLIM : CX;
          w_dxn = w_hit_r;
          w_by  = w_hit_r ? w_y : CY;
          w_sl  = w_hit_r ? r_sl : r_sl + SCORE_W'(1);
        end else if (r_dxn && w_nx <= LLIM) begin
          w_bx  = w_hit_l ? LLIM : CX;
          w_dxn = !w_hit_l;
          w_by  = w_hit_l ? w_y : CY;
          w_sr  = w_hit_l ? r_sr : r_sr + SCORE_W'(1);
        end
        if (w_sl != r_sl || w_sr != r_sr) begin
          w_cnt   = SF;
          w_state = (w_sl == WIN || w_sr == WIN) ? OVER : SERVE;
        end
      end else if (restart) begin
        w_sl    = '0;
        w_sr    = '0;
        w_cnt   = SF;
        w_state = SERVE;
      end
    end
  end
  assign ball_x     = r_bx[9:0];
  assign ball_y     = r_by[9:0];
  assign paddle_l_y = r_pl[9:0];
  assign paddle_r_y = r_pr[9:0];
  assign score_l    = r_sl;
  assign score_r    = r_sr;
  assign state      = r_state;
  assign game_over  = r_go;
endmodule
